// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider and its E-stage decode.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH  = 32;
    localparam int unsigned DIV_CYCLES = DIV_WIDTH;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBZ  = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // ALU operations seen by the E-stage decode; only the divide ops start this unit.
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_MULT = 4'd3,
        ALU_DIV  = 4'd4,
        ALU_DIVU = 4'd5
    } alu_op_t;

    function automatic logic is_div_op(input alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_signed_div(input alu_op_t op);
        return op == ALU_DIV;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the E-stage control path and the divider.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start_i;
    logic               signed_i;
    logic               annul_i;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stall_o;

    modport master (
        output start_i, signed_i, annul_i, a_i, b_i,
        input  result_o, ready_o, stall_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, a_i, b_i,
        output result_o, ready_o, stall_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH:0]     rem_wide;
    logic               rem_ge;
    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_dvd;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return neg_if(v, sgn & v[WIDTH-1]);
    endfunction

    // One restoring step: shift {rem, dividend} left, subtract divisor when it fits.
    always_comb begin
        rem_wide = {rem_q, dvd_q[WIDTH-1]};
        rem_ge   = rem_wide >= {1'b0, dvs_q};
        step_rem = rem_ge ? (rem_wide[WIDTH-1:0] - dvs_q) : rem_wide[WIDTH-1:0];
        step_dvd = {dvd_q[WIDTH-2:0], rem_ge};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, datapath updates and registered outputs.
    always_comb begin
        state_nxt = state;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ready_d   = 1'b0;

        if (bus.annul_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        cnt_d = '0;
                        if (bus.b_i == '0) begin
                            // Divide by zero: quotient all ones, remainder is the raw dividend.
                            state_nxt = DBZ;
                            rem_d     = bus.a_i;
                            dvd_d     = '1;
                            q_neg_d   = 1'b0;
                            r_neg_d   = 1'b0;
                        end else begin
                            state_nxt = CALC;
                            rem_d     = '0;
                            dvd_d     = magnitude(bus.a_i, bus.signed_i);
                            dvs_d     = magnitude(bus.b_i, bus.signed_i);
                            q_neg_d   = (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]) & bus.signed_i;
                            r_neg_d   = bus.a_i[WIDTH-1] & bus.signed_i;
                        end
                    end
                end
                CALC: begin
                    rem_d = step_rem;
                    dvd_d = step_dvd;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // Final step lands with sign fixups so the result is valid in DONE.
                        state_nxt = DONE;
                        result_d  = {neg_if(step_rem, r_neg_q), neg_if(step_dvd, q_neg_q)};
                        ready_d   = 1'b1;
                    end
                end
                DBZ: begin
                    state_nxt = DONE;
                    result_d  = {rem_q, dvd_q};
                    ready_d   = 1'b1;
                end
                DONE: begin
                    state_nxt = IDLE;
                    cnt_d     = '0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    // Hold the instruction in E until the result is valid.
    assign bus.stall_o  = bus.start_i & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized traffic against an arithmetic model.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference division from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Timing model: edges remaining until idle; ready is expected on the edge leaving 2.
    int          left;
    logic [63:0] pend;
    logic [63:0] m_res;
    logic        m_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left    <= 0;
            m_ready <= 1'b0;
            m_res   <= '0;
        end else begin
            m_ready <= 1'b0;
            if (bus.annul_i) begin
                left <= 0;
            end else if (left != 0) begin
                left <= left - 1;
                if (left == 2) begin
                    m_ready <= 1'b1;
                    m_res   <= pend;
                end
            end else if (bus.start_i) begin
                pend <= ref_div(bus.a_i, bus.b_i, bus.signed_i);
                left <= (bus.b_i == 32'd0) ? 2 : W + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", 64'(bus.ready_o), 64'(m_ready));
            chk("result", bus.result_o, m_res);
            chk("stall", 64'(bus.stall_o), 64'(bus.start_i & ~m_ready));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!bus.ready_o && lat < 100);
        if (!bus.ready_o) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: no ready after %0d cycles", lat);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int exp_lat);
        int lat;
        bus.start_i  = 1'b1;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.signed_i = s;
        wait_ready(lat);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_res"}, bus.result_o, exp);
        bus.start_i = 1'b0;
        step();
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 20));
            3:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        int lat;
        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.annul_i  = 1'b0;
        bus.a_i      = '0;
        bus.b_i      = '0;

        repeat (3) step();
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;
        step();

        run_op("u100_7",   32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 33);
        run_op("s-7_2",    32'hFFFF_FFF9,  32'h0000_0002,  1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_op("s7_-2",    32'h0000_0007,  32'hFFFF_FFFE,  1'b1, 64'h00000001_FFFFFFFD, 33);
        run_op("dbz",      32'h1234_5678,  32'h0,          1'b0, 64'h12345678_FFFFFFFF, 2);
        run_op("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h00000000_80000000, 33);
        run_op("u_max_1",  32'hFFFF_FFFF,  32'h1,          1'b0, 64'h00000000_FFFFFFFF, 33);

        // Flush mid-CALC: no result, then a fresh op with full latency.
        bus.start_i  = 1'b1;
        bus.a_i      = 32'd100;
        bus.b_i      = 32'd7;
        bus.signed_i = 1'b0;
        repeat (10) step();
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        step();
        bus.annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            step();
            if (bus.ready_o) seen++;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run_op("u9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);

        // annul and start together in IDLE: nothing launches.
        bus.start_i = 1'b1;
        bus.annul_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            step();
            if (bus.ready_o) seen++;
        end
        chk("annul_start_idle", 64'(seen), 64'd0);

        // Asynchronous reset between edges mid-CALC.
        bus.start_i = 1'b1;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        repeat (10) step();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", 64'(bus.ready_o), 64'd0);
        chk("async_rst_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Operand churn during CALC must not affect the latched operation.
        bus.start_i  = 1'b1;
        bus.a_i      = 32'd1000;
        bus.b_i      = 32'd10;
        bus.signed_i = 1'b0;
        repeat (3) step();
        bus.a_i      = 32'd5;
        bus.b_i      = 32'd0;
        bus.signed_i = 1'b1;
        wait_ready(lat);
        chk("churn_lat", 64'(lat), 64'd30);
        chk("churn_res", bus.result_o, 64'h00000000_00000064);
        bus.start_i = 1'b0;
        step();

        // Randomized traffic with occasional flushes and start held into DONE.
        repeat (4000) begin
            step();
            if ($urandom_range(0, 49) == 0) begin
                bus.annul_i = 1'b1;
                bus.start_i = 1'b0;
            end else begin
                bus.annul_i = 1'b0;
                if (!bus.start_i) begin
                    if ($urandom_range(0, 2) == 0) bus.start_i = 1'b1;
                end else if (m_ready && $urandom_range(0, 1) == 0) begin
                    bus.start_i = 1'b0;
                end
            end
            bus.a_i      = rand_opnd();
            bus.b_i      = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_opnd();
            bus.signed_i = 1'($urandom_range(0, 1));
        end
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
